// File: rtl/sll_traverser.sv
// sll_traverser
//   Initiator-side companion to the singly linked list block. Walks the list
//   from head to tail with Read ops, streams each node (data, address, last)
//   on a valid/ready port and cross-checks the walk against the list length.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   start, abort        begin traversal (IDLE only) / stop early
//   busy, done, fault   status: busy span, 1-cycle done pulse, sticky fault
//   count               beats accepted in the current/last traversal
//   ll_*  (outputs)     op request to the list (op always Read, data tied 0)
//   ll_*  (inputs)      op completion, read data/next pointer, list status
//   m_*                 node stream: valid/ready with data, address, last
module sll_traverser #(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_NODE   = 8,
    localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] count,
    output logic [2:0]            ll_op,
    output logic [ADDR_WIDTH-1:0] ll_addr,
    output logic [DATA_WIDTH-1:0] ll_data,
    output logic                  ll_op_start,
    input  logic                  ll_op_done,
    input  logic [DATA_WIDTH-1:0] ll_data_out,
    input  logic [ADDR_WIDTH-1:0] ll_next_node_addr,
    input  logic                  ll_fault,
    input  logic [ADDR_WIDTH-1:0] ll_head,
    input  logic [ADDR_WIDTH-1:0] ll_length,
    input  logic                  ll_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_NULL = ADDR_WIDTH'(MAX_NODE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   cur_q,     cur_d;
    logic [ADDR_WIDTH-1:0]   nxt_q,     nxt_d;
    logic [ADDR_WIDTH-1:0]   len_q,     len_d;
    logic [ADDR_WIDTH-1:0]   count_q,   count_d;
    logic                    abort_q,   abort_d;
    logic                    fault_q,   fault_d;
    logic [DATA_WIDTH-1:0]   mdata_q,   mdata_d;
    logic [ADDR_WIDTH-1:0]   maddr_q,   maddr_d;
    logic                    mlast_q,   mlast_d;
    logic                    opstart_q;
    logic                    mvalid_q;
    logic [ADDR_WIDTH-1:0]   beats;

    assign beats = count_q + ADDR_WIDTH'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cur_q     <= ADDR_NULL;
            nxt_q     <= ADDR_NULL;
            len_q     <= '0;
            count_q   <= '0;
            abort_q   <= 1'b0;
            fault_q   <= 1'b0;
            mdata_q   <= '0;
            maddr_q   <= '0;
            mlast_q   <= 1'b0;
            opstart_q <= 1'b0;
            mvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            len_q     <= len_d;
            count_q   <= count_d;
            abort_q   <= abort_d;
            fault_q   <= fault_d;
            mdata_q   <= mdata_d;
            maddr_q   <= maddr_d;
            mlast_q   <= mlast_d;
            // Request/valid are registered off the next state so they are
            // glitch-free and drop in the same cycle the FSM leaves REQ/EMIT.
            opstart_q <= (state_d == S_REQ);
            mvalid_q  <= (state_d == S_EMIT);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        len_d   = len_q;
        count_d = count_q;
        abort_d = abort_q;
        fault_d = fault_q;
        mdata_d = mdata_q;
        maddr_d = maddr_q;
        mlast_d = mlast_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    count_d = '0;
                    fault_d = 1'b0;
                    abort_d = 1'b0;
                    if (ll_empty) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = ll_head;
                        len_d   = ll_length;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (abort) abort_d = 1'b1;
                if (ll_op_done) begin
                    if (ll_fault) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else if (abort_q || abort) begin
                        // abort landing on the completion cycle is honoured too
                        state_d = S_DONE;
                    end else begin
                        mdata_d = ll_data_out;
                        maddr_d = cur_q;
                        nxt_d   = ll_next_node_addr;
                        mlast_d = (ll_next_node_addr == ADDR_NULL);
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (m_ready) begin
                    count_d = beats;
                    if (mlast_q) begin
                        if (beats != len_q) fault_d = 1'b1;
                        state_d = S_DONE;
                    end else if (beats >= len_q) begin
                        // Tail not reached within the advertised length:
                        // either a pointer loop or a lost tail.
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else if (abort) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = nxt_q;
                        state_d = S_REQ;
                    end
                end else if (abort) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        fault       = fault_q;
        count       = count_q;
        ll_op       = '0;
        ll_data     = '0;
        ll_op_start = opstart_q;
        ll_addr     = opstart_q ? cur_q : '0;
        m_valid     = mvalid_q;
        m_data      = mdata_q;
        m_addr      = maddr_q;
        m_last      = mlast_q;
    end

endmodule
